framebuf_loader: RTL and testbench
==================================

Name: framebuf_loader

Overview:
- Upstream stage of the HUB75 panel scanner: receives a raster-order RGB pixel stream and writes it into the double-buffered 48-bit frame RAM that the scanner reads.
- Each RAM word holds two pixels: upper half = row r (drives rgb1), lower half = row r+panel_height/2 (drives rgb2).
- Writes go to the back bank. The bank select toggles only when the scanner signals the end of a refresh pass, so the display never shows a torn frame.

Parameters:
- pixel_depth, 8, bits per colour channel
- panel_width, 64, pixels per row
- panel_height, 32, rows per frame
- addr_width, 10, word address width of one RAM bank (panel_width*panel_height/2 words)
- data_width, 48, RAM word width = 6*pixel_depth

Ports:
- clk_in  in  1  system clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- s_valid  in  1  pixel stream valid
- s_ready  out  1  loader can accept a pixel
- s_sof  in  1  start of frame, qualifies the pixel at index 0
- s_pixel  in  3*pixel_depth  pixel {R,G,B}, R in MSBs
- frame_end  in  1  one-cycle pulse from the scanner when a full refresh pass completes (row address wraps 15->0)
- wr_en  out  1  RAM write strobe
- wr_addr  out  addr_width+1  {bank, word}
- wr_data  out  data_width  pixel replicated into both halves
- wr_be  out  2  half enables: [1] = upper 24 bits, [0] = lower 24 bits
- disp_bank  out  1  bank the scanner must read (RAM read-address MSB)
- err  out  1  one-cycle pulse on a protocol error
- frame_count  out  8  completed and swapped frames, wraps at 255

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; col=0, row=0.
  - disp_bank=0; write bank = ~disp_bank = 1.
  - wr_en=0, wr_addr=0, wr_data=0, wr_be=0, err=0, frame_count=0.
  - s_ready is combinational from state, so it reads 1 in reset.
  - Reset mid-frame discards the partial frame; the next frame must start with sof.
- Handshake: a transfer occurs on a rising edge with s_valid && s_ready. s_ready=1 in IDLE and WRITE, 0 in WAIT_SWAP.
- States:
  - IDLE: a transfer with s_sof=0 is accepted and dropped (no write). A transfer with s_sof=1 writes pixel (row 0, col 0), sets col=1, goes to WRITE.
  - WRITE:
    - Each transfer writes the pixel at (row, col), then col++.
    - At col=panel_width-1: col wraps to 0, row++.
    - The transfer at row=panel_height-1, col=panel_width-1 goes to WAIT_SWAP.
    - A transfer with s_sof=1 in WRITE: err=1 for one cycle; the pixel is written as (0,0); counters restart at col=1, row=0. The bank is not swapped.
  - WAIT_SWAP:
    - On frame_end=1: disp_bank toggles, frame_count++, state goes to IDLE.
    - frame_end outside WAIT_SWAP is ignored. This includes the same cycle as the last-pixel transfer; the loader then waits for the next pulse.
- Write mapping, registered with 1-cycle latency: outputs appear the cycle after the transfer, wr_en high for exactly one cycle per written pixel.
  - half = (row >= panel_height/2); word = (row mod panel_height/2)*panel_width + col.
  - wr_addr = {~disp_bank, word}.
  - wr_data = {s_pixel, s_pixel}.
  - wr_be = 2'b10 if half=0, 2'b01 if half=1.
  - Dropped pixels produce no write.
- Bank in wr_addr is sampled at transfer time. Since swaps happen only in WAIT_SWAP, no write ever targets disp_bank.
- Back-to-back transfers every cycle are supported: full throughput, 1 pixel/clk.
- Arithmetic: col is log2(panel_width) bits and row is log2(panel_height) bits; both wrap by explicit compare, not overflow. frame_count wraps 255->0.

Test Plan:
- Reset, then sof + 2048 consecutive pixels, pixel value = index -> 2048 writes. Pixel 0: wr_addr={1,0}, wr_be=10, data=0. Pixel 1024 (row 16, col 0): wr_addr={1,0}, wr_be=01. Last pixel: wr_addr={1,1023}, wr_be=01. After the last pixel, s_ready=0.
- In WAIT_SWAP, pulse frame_end -> next cycle disp_bank=1, frame_count=1, s_ready=1. The next frame's writes use bank bit 0.
- Give 5 pixels with sof=0 while IDLE -> no wr_en. A following sof pixel is written to word 0.
- After 100 pixels of a frame, assert sof -> err pulses exactly once, that pixel is written to word 0 upper, and the frame completes after 2047 further pixels.
- Toggle s_valid randomly during a frame -> writes occur only on handshake cycles and addresses stay contiguous. frame_end pulses during WRITE cause no swap.
- Assert rst low at pixel 700 -> all outputs go to reset values immediately, disp_bank=0, and a new sof frame writes bank 1 from word 0.

Source files
------------

// File: rtl/framebuf_loader.sv
// framebuf_loader
//   Accepts a raster-order RGB pixel stream and writes it into the back bank
//   of a double-buffered frame RAM. Each RAM word packs two pixels: the upper
//   half feeds the top panel half (rgb1), the lower half feeds the bottom
//   panel half (rgb2). The bank seen by the scanner only flips on a scanner
//   frame_end pulse after a complete frame has been written.
//
// Ports:
//   clk_in       system clock
//   rst          asynchronous reset, active low
//   s_valid      pixel stream valid
//   s_ready      loader can accept a pixel (low while waiting for a swap)
//   s_sof        start of frame, marks pixel index 0
//   s_pixel      {R,G,B}, R in the MSBs
//   frame_end    scanner pulse at the end of a refresh pass
//   wr_en        RAM write strobe (one cycle per written pixel)
//   wr_addr      {bank, word}
//   wr_data      pixel replicated into both halves
//   wr_be        half enables: [1] upper 24 bits, [0] lower 24 bits
//   disp_bank    bank the scanner reads
//   err          one-cycle pulse when sof arrives in the middle of a frame
//   frame_count  completed and swapped frames, wraps at 255
module framebuf_loader #(
    parameter int pixel_depth  = 8,
    parameter int panel_width  = 64,
    parameter int panel_height = 32,
    parameter int addr_width   = 10,
    parameter int data_width   = 6 * pixel_depth
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_sof,
    input  logic [3*pixel_depth-1:0] s_pixel,
    input  logic                     frame_end,
    output logic                     wr_en,
    output logic [addr_width:0]      wr_addr,
    output logic [data_width-1:0]    wr_data,
    output logic [1:0]               wr_be,
    output logic                     disp_bank,
    output logic                     err,
    output logic [7:0]               frame_count
);

    localparam int col_w = $clog2(panel_width);
    localparam int row_w = $clog2(panel_height);

    localparam logic [col_w-1:0] col_last = col_w'(panel_width - 1);
    localparam logic [row_w-1:0] row_last = row_w'(panel_height - 1);
    localparam logic [row_w-1:0] row_half = row_w'(panel_height / 2);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_SWAP
    } state_t;

    state_t           state, state_n;
    logic [col_w-1:0] col, col_n;
    logic [row_w-1:0] row, row_n;
    logic             disp_bank_n;
    logic [7:0]       frame_count_n;

    logic             xfer;
    logic             wr_c;
    logic             err_c;
    logic [col_w-1:0] wcol;
    logic [row_w-1:0] wrow;
    logic [row_w-1:0] wrow_lo;
    logic             half;
    logic [addr_width-1:0] word;

    assign s_ready = (state != WAIT_SWAP);
    assign xfer    = s_valid && s_ready;

    // Next state, counters and the (row, col) the current transfer writes.
    always_comb begin
        state_n       = state;
        col_n         = col;
        row_n         = row;
        disp_bank_n   = disp_bank;
        frame_count_n = frame_count;
        wr_c          = 1'b0;
        err_c         = 1'b0;
        wcol          = col;
        wrow          = row;

        case (state)
            IDLE: begin
                // Pixels without sof are accepted and discarded here.
                if (xfer && s_sof) begin
                    wr_c    = 1'b1;
                    wcol    = '0;
                    wrow    = '0;
                    col_n   = col_w'(1);
                    row_n   = '0;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (xfer) begin
                    wr_c = 1'b1;
                    if (s_sof) begin
                        // Unexpected sof: restart the frame in the same bank.
                        err_c = 1'b1;
                        wcol  = '0;
                        wrow  = '0;
                        col_n = col_w'(1);
                        row_n = '0;
                    end else if (col == col_last) begin
                        col_n = '0;
                        if (row == row_last) begin
                            row_n   = '0;
                            state_n = WAIT_SWAP;
                        end else begin
                            row_n = row + row_w'(1);
                        end
                    end else begin
                        col_n = col + col_w'(1);
                    end
                end
            end
            WAIT_SWAP: begin
                if (frame_end) begin
                    disp_bank_n   = ~disp_bank;
                    frame_count_n = frame_count + 8'd1;
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Fold the bottom panel half onto the same word range as the top half.
    always_comb begin
        half    = (wrow >= row_half);
        wrow_lo = half ? (wrow - row_half) : wrow;
        word    = addr_width'(wrow_lo) * addr_width'(panel_width) + addr_width'(wcol);
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            disp_bank   <= 1'b0;
            frame_count <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_be       <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            row         <= row_n;
            disp_bank   <= disp_bank_n;
            frame_count <= frame_count_n;
            wr_en       <= wr_c;
            err         <= err_c;
            if (wr_c) begin
                wr_addr <= {~disp_bank, word};
                wr_data <= {s_pixel, s_pixel};
                wr_be   <= half ? 2'b01 : 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_framebuf_loader.sv
module tb_framebuf_loader;

    localparam int PD     = 8;
    localparam int PW     = 64;
    localparam int PH     = 32;
    localparam int AW     = 10;
    localparam int DW     = 6 * PD;
    localparam int NPIX   = PW * PH;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic          s_sof;
    logic [3*PD-1:0] s_pixel;
    logic          frame_end;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    wr_be;
    logic          disp_bank;
    logic          err;
    logic [7:0]    frame_count;

    framebuf_loader #(
        .pixel_depth (PD),
        .panel_width (PW),
        .panel_height(PH),
        .addr_width  (AW),
        .data_width  (DW)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_sof      (s_sof),
        .s_pixel    (s_pixel),
        .frame_end  (frame_end),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .disp_bank  (disp_bank),
        .err        (err),
        .frame_count(frame_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [AW:0]   addr;
        logic [DW-1:0] data;
        logic [1:0]    be;
    } wr_exp_t;

    wr_exp_t sb[$];

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    int unsigned err_seen = 0;
    int unsigned exp_err = 0;

    // Reference model state, kept as a linear pixel index within the frame.
    logic        exp_bank;
    logic [7:0]  exp_fc;
    bit          in_frame;
    bit          waiting;
    int unsigned idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected write for raster pixel index i of the frame in the back bank.
    task automatic push_write(input int unsigned i, input logic [3*PD-1:0] pix);
        wr_exp_t e;
        int unsigned r, c;
        r = i / PW;
        c = i % PW;
        e.addr = {exp_bank, AW'((r % (PH / 2)) * PW + c)};
        e.data = {pix, pix};
        e.be   = (r < PH / 2) ? 2'b10 : 2'b01;
        sb.push_back(e);
    endtask

    task automatic model_xfer(input logic sof, input logic [3*PD-1:0] pix);
        if (sof) begin
            if (in_frame) exp_err++;
            push_write(0, pix);
            idx      = 1;
            in_frame = 1;
        end else if (in_frame) begin
            push_write(idx, pix);
            idx++;
        end
        if (in_frame && idx == NPIX) begin
            in_frame = 0;
            waiting  = 1;
        end
    endtask

    // Called at posedge+1; drives one beat that transfers on the next edge.
    task automatic send(input logic sof, input logic [3*PD-1:0] pix);
        check("s_ready_before_xfer", {63'd0, s_ready}, 64'd1);
        model_xfer(sof, pix);
        s_valid = 1'b1;
        s_sof   = sof;
        s_pixel = pix;
        @(posedge clk_in); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk_in); #1;
        end
    endtask

    task automatic swap();
        check("s_ready_wait_swap", {63'd0, s_ready}, 64'd0);
        frame_end = 1'b1;
        @(posedge clk_in); #1;
        frame_end = 1'b0;
        exp_bank = ~exp_bank;
        exp_fc   = exp_fc + 8'd1;
        waiting  = 0;
        check("disp_bank_swap", {63'd0, disp_bank}, {63'd0, ~exp_bank});
        check("frame_count_swap", {56'd0, frame_count}, {56'd0, exp_fc});
        check("s_ready_after_swap", {63'd0, s_ready}, 64'd1);
    endtask

    // Scoreboard: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk_in) begin
        if (err) err_seen++;
        if (wr_en) begin
            if (sb.size() == 0) begin
                check("spurious_write", {63'd0, wr_en}, 64'd0);
            end else begin
                wr_exp_t e;
                e = sb.pop_front();
                check("wr_addr", {53'd0, wr_addr}, {53'd0, e.addr});
                check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
                check("wr_be",   {62'd0, wr_be},   {62'd0, e.be});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},     {63'd0, wr_en},       64'd0);
        check({tag, "_wr_addr"},   {53'd0, wr_addr},     64'd0);
        check({tag, "_wr_data"},   {16'd0, wr_data},     64'd0);
        check({tag, "_wr_be"},     {62'd0, wr_be},       64'd0);
        check({tag, "_err"},       {63'd0, err},         64'd0);
        check({tag, "_disp_bank"}, {63'd0, disp_bank},   64'd0);
        check({tag, "_fcount"},    {56'd0, frame_count}, 64'd0);
        check({tag, "_s_ready"},   {63'd0, s_ready},     64'd1);
    endtask

    initial begin
        rst       = 1'b0;
        s_valid   = 1'b0;
        s_sof     = 1'b0;
        s_pixel   = '0;
        frame_end = 1'b0;
        exp_bank  = 1'b1;
        exp_fc    = 8'd0;
        in_frame  = 0;
        waiting   = 0;
        idx       = 0;

        #22;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk_in); #1;

        // Frame 1: pixel value = index; frame_end on the last beat must be ignored.
        for (int i = 0; i < NPIX; i++) begin
            if (i == NPIX - 1) frame_end = 1'b1;
            send(i == 0, 24'(i));
            frame_end = 1'b0;
        end
        idle(3);
        check("s_ready_last_pixel", {63'd0, s_ready}, 64'd0);
        check("no_swap_on_last_beat", {63'd0, disp_bank}, 64'd0);
        check("queue_empty_f1", 64'(sb.size()), 64'd0);
        swap();

        // Non-sof pixels in IDLE are dropped, then sof restart after 100 pixels.
        for (int i = 0; i < 5; i++) send(1'b0, 24'hA00000 + 24'(i));
        idle(2);
        check("queue_empty_drop", 64'(sb.size()), 64'd0);
        for (int i = 0; i < 100; i++) send(i == 0, 24'h100000 + 24'(i));
        send(1'b1, 24'hBEEF01);
        for (int i = 1; i < NPIX; i++) send(1'b0, 24'h200000 + 24'(i));
        idle(3);
        check("err_count_restart", 64'(err_seen), 64'(exp_err));
        check("err_expected_once", 64'(exp_err), 64'd1);
        check("s_ready_f2_done", {63'd0, s_ready}, 64'd0);
        swap();

        // Frame 3: random valid gaps with stray frame_end pulses during WRITE.
        for (int i = 0; i < NPIX; i++) begin
            repeat ($urandom_range(0, 2)) begin
                frame_end = ($urandom_range(0, 3) == 0);
                @(posedge clk_in); #1;
                frame_end = 1'b0;
            end
            send(i == 0, 24'($urandom));
        end
        idle(2);
        check("no_swap_during_write", {63'd0, disp_bank}, {63'd0, ~exp_bank});
        check("fcount_during_write", {56'd0, frame_count}, {56'd0, exp_fc});
        swap();

        // Frame 4: asynchronous reset at pixel 700.
        for (int i = 0; i < 700; i++) send(i == 0, 24'h300000 + 24'(i));
        @(negedge clk_in); #1;
        check("queue_empty_pre_rst", 64'(sb.size()), 64'd0);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_bank = 1'b1;
        exp_fc   = 8'd0;
        in_frame = 0;
        waiting  = 0;
        #1;
        rst = 1'b1;
        @(posedge clk_in); #1;

        for (int i = 0; i < NPIX; i++) send(i == 0, 24'h400000 + 24'(i));
        idle(2);
        swap();
        idle(3);
        check("queue_empty_end", 64'(sb.size()), 64'd0);
        check("err_count_end", 64'(err_seen), 64'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
